// File: rtl/mem_block_responder_pkg.sv
// Shared constants and FSM state encoding for the block-read responder.
package mem_pkg;

  localparam int BLK_WORDS = 4;
  localparam int WORD_W    = 32;
  localparam int BLK_W     = BLK_WORDS * WORD_W;
  localparam int BADDR_W   = 13;
  localparam int WADDR_W   = BADDR_W + $clog2(BLK_WORDS);

  // 2'd3 is never entered; the FSM falls back to S_IDLE if it is ever seen.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_RESP  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_block_responder_if.sv
// Cache-to-memory refill bus: block read request/response plus a word write port.
interface mem_block_responder_if;
  import mem_pkg::*;

  logic               req_valid;
  logic               req_ready;
  logic [BADDR_W-1:0] req_baddr;
  logic               resp_valid;
  logic               resp_ready;
  logic [BLK_W-1:0]   resp_data;
  logic               wr_en;
  logic [WADDR_W-1:0] wr_addr;
  logic [WORD_W-1:0]  wr_data;

  // Cache / testbench side.
  modport master (
    output req_valid, req_baddr, resp_ready, wr_en, wr_addr, wr_data,
    input  req_ready, resp_valid, resp_data
  );

  // Memory responder side.
  modport slave (
    input  req_valid, req_baddr, resp_ready, wr_en, wr_addr, wr_data,
    output req_ready, resp_valid, resp_data
  );

endinterface

// File: rtl/mem_block_responder_word_ram.sv
// Word-wide backing store: combinational read, synchronous write, never reset.
module word_ram #(
  parameter int DEPTH     = 32768,
  parameter int DATA_W    = 32,
  parameter     INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [DATA_W-1:0]        rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Write port; a same-edge read still sees the old word.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mem_block_responder.sv
// Serves 4-word block reads to the data cache with programmable wait states per beat.
module mem_block_responder #(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 32,
  parameter int BLK_WORDS   = 4,
  parameter int WAIT_CYCLES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_block_responder_if.slave  bus
);
  import mem_pkg::*;

  localparam int                BEAT_W    = $clog2(BLK_WORDS);
  localparam int                BADDR_L   = ADDR_W - BEAT_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BLK_WORDS - 1);
  localparam logic [3:0]        WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_e                        state_q, state_d;
  logic [BADDR_L-1:0]            baddr_q, baddr_d;
  logic [BEAT_W-1:0]             beat_q, beat_d;
  logic [3:0]                    wcnt_q, wcnt_d;
  logic [BLK_WORDS*DATA_W-1:0]   data_q, data_d;
  logic [ADDR_W-1:0]             rd_addr;
  logic [DATA_W-1:0]             rd_data;
  logic                          capture;
  logic [BLK_WORDS-1:0]          lane_we;

  // The word address is the latched block address with the beat as its low bits.
  assign rd_addr = {baddr_q, beat_q};
  assign capture = (state_q == S_FETCH) && (wcnt_q == WAIT_LAST);

  word_ram #(
    .DEPTH     (2**ADDR_W),
    .DATA_W    (DATA_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk     (clk),
    .we_i    (bus.wr_en),
    .waddr_i (bus.wr_addr),
    .wdata_i (bus.wr_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  // Each lane of the line register loads only on its own beat's terminal wait count.
  genvar gi;
  generate
    for (gi = 0; gi < BLK_WORDS; gi++) begin : g_lane
      assign lane_we[gi] = capture && (beat_q == BEAT_W'(gi));
      assign data_d[gi*DATA_W +: DATA_W] = lane_we[gi] ? rd_data
                                                       : data_q[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Next-state logic for the FSM, the beat/wait counters and the latched block address.
  always_comb begin
    state_d = state_q;
    baddr_d = baddr_q;
    beat_d  = beat_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          baddr_d = bus.req_baddr;
          beat_d  = '0;
          wcnt_d  = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (capture) begin
          wcnt_d = '0;
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST_BEAT) begin
            state_d = S_RESP;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (bus.resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      baddr_q <= '0;
      beat_q  <= '0;
      wcnt_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      baddr_q <= baddr_d;
      beat_q  <= beat_d;
      wcnt_q  <= wcnt_d;
      data_q  <= data_d;
    end
  end

  // Handshake outputs decode straight from the state register so reset shows at once.
  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.resp_valid = (state_q == S_RESP);
  assign bus.resp_data  = data_q;

endmodule

// File: tb/tb_mem_block_responder.sv
// Directed test of mem_block_responder with one-wait and three-wait instances.
module tb_mem_block_responder;
  import mem_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks_cnt = 0;
  int   errors_cnt = 0;

  mem_block_responder_if bus1();
  mem_block_responder_if bus3();

  mem_block_responder #(.WAIT_CYCLES(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  mem_block_responder #(.WAIT_CYCLES(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr1(input logic [14:0] a, input logic [31:0] d);
    bus1.wr_en = 1'b1; bus1.wr_addr = a; bus1.wr_data = d;
    @(posedge clk); #1;
    bus1.wr_en = 1'b0;
  endtask

  task automatic wr3(input logic [14:0] a, input logic [31:0] d);
    bus3.wr_en = 1'b1; bus3.wr_addr = a; bus3.wr_data = d;
    @(posedge clk); #1;
    bus3.wr_en = 1'b0;
  endtask

  // Request on dut1; optional write landing on edge E+wr_at, optional stray request during FETCH.
  task automatic req1(input logic [12:0] baddr, input int wr_at, input logic [14:0] waddr,
                      input logic [31:0] wdata, input int dup,
                      output int lat, output logic [127:0] data);
    int guard;
    guard = 0;
    bus1.req_valid = 1'b1; bus1.req_baddr = baddr;
    while (bus1.req_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check_val("dut1_accept_timeout", 128'(guard >= 50), 128'd0);
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    lat = 0;
    while (bus1.resp_valid !== 1'b1 && lat < 50) begin
      if (wr_at > 0 && lat == wr_at - 1) begin
        bus1.wr_en = 1'b1; bus1.wr_addr = waddr; bus1.wr_data = wdata;
      end else begin
        bus1.wr_en = 1'b0;
      end
      if (dup != 0 && lat >= 1 && lat <= 2) begin
        bus1.req_valid = 1'b1; bus1.req_baddr = 13'h1FFF;
      end else begin
        bus1.req_valid = 1'b0;
      end
      @(posedge clk); #1; lat++;
    end
    bus1.wr_en = 1'b0; bus1.req_valid = 1'b0;
    data = bus1.resp_data;
    $display("TXN dut1 baddr=%h lat=%0d data=%h", baddr, lat, data);
  endtask

  task automatic req3(input logic [12:0] baddr, output int lat, output logic [127:0] data);
    int guard;
    guard = 0;
    bus3.req_valid = 1'b1; bus3.req_baddr = baddr;
    while (bus3.req_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check_val("dut3_accept_timeout", 128'(guard >= 50), 128'd0);
    @(posedge clk); #1;
    bus3.req_valid = 1'b0;
    lat = 0;
    while (bus3.resp_valid !== 1'b1 && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    data = bus3.resp_data;
    $display("TXN dut3 baddr=%h lat=%0d data=%h", baddr, lat, data);
  endtask

  initial begin
    int           lat;
    int           n;
    logic [127:0] data;
    logic [127:0] held;
    logic [127:0] exp_orig;
    logic [127:0] exp_ff;
    logic [127:0] exp_ee;

    exp_orig = {32'h000000A3, 32'h000000A2, 32'h000000A1, 32'h000000A0};
    exp_ff   = {32'h000000FF, 32'h000000A2, 32'h000000A1, 32'h000000A0};
    exp_ee   = {32'h000000FF, 32'h000000A2, 32'h000000EE, 32'h000000A0};

    rst = 1'b0;
    bus1.req_valid = 1'b0; bus1.req_baddr = '0; bus1.resp_ready = 1'b0;
    bus1.wr_en = 1'b0; bus1.wr_addr = '0; bus1.wr_data = '0;
    bus3.req_valid = 1'b0; bus3.req_baddr = '0; bus3.resp_ready = 1'b0;
    bus3.wr_en = 1'b0; bus3.wr_addr = '0; bus3.wr_data = '0;

    // Reset state
    #2;
    check_val("rst_req_ready", 128'(bus1.req_ready), 128'd1);
    check_val("rst_resp_valid", 128'(bus1.resp_valid), 128'd0);
    check_val("rst_resp_data", bus1.resp_data, 128'd0);
    check_val("rst_req_ready3", 128'(bus3.req_ready), 128'd1);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;

    // Preload
    for (int i = 0; i < 4; i++) wr1(15'(16'h0040 + i), 32'(8'hA0 + i));
    for (int i = 0; i < 4; i++) wr3(15'(16'h7FFC + i), 32'(i + 1));

    // Basic block read, consumed immediately
    bus1.resp_ready = 1'b1;
    req1(13'h0010, 0, '0, '0, 0, lat, data);
    check_val("basic_latency", 128'(lat), 128'd4);
    check_val("basic_data", data, exp_orig);
    @(posedge clk); #1;
    check_val("basic_valid_drop", 128'(bus1.resp_valid), 128'd0);
    check_val("basic_ready_rise", 128'(bus1.req_ready), 128'd1);

    // Backpressure: hold resp_ready low for 10 cycles
    bus1.resp_ready = 1'b0;
    req1(13'h0010, 0, '0, '0, 0, lat, data);
    check_val("hold_latency", 128'(lat), 128'd4);
    check_val("hold_data", data, exp_orig);
    held = data;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_val("hold_valid", 128'(bus1.resp_valid), 128'd1);
      check_val("hold_req_ready", 128'(bus1.req_ready), 128'd0);
      check_val("hold_stable", bus1.resp_data, held);
    end
    bus1.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus1.resp_ready = 1'b0;
    check_val("pulse_valid_drop", 128'(bus1.resp_valid), 128'd0);
    check_val("pulse_ready_rise", 128'(bus1.req_ready), 128'd1);
    bus1.resp_ready = 1'b1;

    // Highest block with three wait cycles per beat
    bus3.resp_ready = 1'b1;
    req3(13'h1FFF, lat, data);
    check_val("w3_latency", 128'(lat), 128'd12);
    check_val("w3_data", data, {32'd4, 32'd3, 32'd2, 32'd1});
    @(posedge clk); #1;
    check_val("w3_valid_drop", 128'(bus3.resp_valid), 128'd0);

    // Write to a later word while beat 1 is active: seen by beat 3
    req1(13'h0010, 2, 15'h0043, 32'h000000FF, 0, lat, data);
    check_val("wr_future_latency", 128'(lat), 128'd4);
    check_val("wr_future_data", data, exp_ff);
    @(posedge clk); #1;

    // Write on the edge capturing beat 1: old data captured
    req1(13'h0010, 2, 15'h0041, 32'h000000EE, 0, lat, data);
    check_val("wr_same_edge_data", data, exp_ff);
    @(posedge clk); #1;

    // Follow-up read sees the write
    req1(13'h0010, 0, '0, '0, 0, lat, data);
    check_val("wr_after_data", data, exp_ee);
    @(posedge clk); #1;

    // Reset mid-FETCH, asserted between edges
    bus1.req_valid = 1'b1; bus1.req_baddr = 13'h0010;
    @(posedge clk); #1;
    bus1.req_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    check_val("midrst_req_ready", 128'(bus1.req_ready), 128'd1);
    check_val("midrst_resp_valid", 128'(bus1.resp_valid), 128'd0);
    check_val("midrst_resp_data", bus1.resp_data, 128'd0);
    @(negedge clk); rst = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus1.resp_valid === 1'b1) n++;
    end
    check_val("midrst_no_resp", 128'(n), 128'd0);
    $display("TXN dut1 reset mid-fetch, spurious responses=%0d", n);

    // Memory intact after reset
    req1(13'h0010, 0, '0, '0, 0, lat, data);
    check_val("postrst_latency", 128'(lat), 128'd4);
    check_val("postrst_data", data, exp_ee);
    @(posedge clk); #1;

    // Stray request during FETCH is ignored
    req1(13'h0010, 0, '0, '0, 1, lat, data);
    check_val("dup_latency", 128'(lat), 128'd4);
    check_val("dup_data", data, exp_ee);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus1.resp_valid === 1'b1) n++;
    end
    check_val("dup_single_resp", 128'(n), 128'd0);
    check_val("dup_idle_ready", 128'(bus1.req_ready), 128'd1);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
